// File: rtl/uart_tx_framer.sv
// UART 8N1 transmitter, LSB first, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 13021,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc;
  logic [2:0]       idx_nxt;

  assign tc      = (cnt_q == CNT_LAST);
  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tc) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_nxt;
            tx_d  = shift_q[idx_nxt];
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shift_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tc) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset forces the line idle at once, abandoning any frame in flight.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer at CLKS_PER_BIT=16.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_framer;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       TX;
  logic       busy;
  logic       tx_done;

  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  bit         mon_en = 1'b1;
  logic [7:0] sb[$];
  time        t_starts[$];

  uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset_p(reset_p),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TX(TX),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  // Frame monitor: detect TX fall, sample each bit mid-period.
  initial begin : mon
    logic        prev;
    logic [15:0] bits;
    logic [7:0]  got, exp;
    int          early;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !reset_p && prev && !TX) begin
        t_starts.push_back($time);
        bits  = '0;
        early = 0;
        for (int i = 1; i <= FRAME; i++) begin
          @(negedge clk);
          if (i < FRAME && (i % CPB) == CPB / 2) bits[i / CPB] = TX;
          if (i < FRAME && tx_done) early++;
        end
        chk("done_at_end", {31'd0, tx_done}, 1);
        chk("ready_at_end", {31'd0, tx_ready}, 1);
        chk("busy_at_end", {31'd0, busy}, 0);
        chk("done_early", early, 0);
        chk("start_bit", {31'd0, bits[0]}, 0);
        chk("stop_bit", {31'd0, bits[NB-1]}, 1);
        got = bits[8:1];
        if (sb.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          exp = sb.pop_front();
          chk("byte", {24'd0, got}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
          chk("parity", {31'd0, bits[9]}, {31'd0, ^exp});
`endif
        end
        prev = TX;
      end else begin
        prev = TX;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit push, input bit hold);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) sb.push_back(b);
    n = 0;
    while (!tx_ready && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("accept_timeout", 1, 0);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (sb.size() != 0 || busy)}, 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    int dc0;
    reset_p  = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, TX}, 1);
    chk("rst_ready", {31'd0, tx_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, tx_done}, 0);
    reset_p = 1'b0;
    @(negedge clk);

    send(8'h30, 1, 0);
    wait_done();
    chk("done_cnt_1", done_cnt, 1);

    t_starts.delete();
    send(8'h55, 1, 1);
    send(8'hAA, 1, 0);
    wait_done();
    chk("done_cnt_b2b", done_cnt, 3);
    if (t_starts.size() == 2)
      chk("b2b_gap", int'((t_starts[1] - t_starts[0]) / 10), FRAME + 1);
    else
      chk("b2b_starts", t_starts.size(), 2);

    send(8'h0F, 1, 0);
    repeat (39) @(negedge clk);
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tx_valid = 1'b0;
    wait_done();
    chk("done_cnt_chg", done_cnt, 4);

    mon_en = 1'b0;
    send(8'h36, 0, 0);
    repeat (75) @(negedge clk);
    dc0 = done_cnt;
    reset_p = 1'b1;
    #1;
    chk("midrst_tx", {31'd0, TX}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("midrst_tx_hold", {31'd0, TX}, 1);
    reset_p = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, tx_ready}, 1);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_nodone", done_cnt, dc0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h34, 1, 0);
    wait_done();
    chk("done_cnt_rst", done_cnt, dc0 + 1);

    send(8'h31, 1, 0);
    wait_done();
    for (int k = 0; k < 4; k++) begin
      send(8'($urandom_range(0, 255)), 1, 0);
      wait_done();
    end
    chk("done_cnt_all", done_cnt, dc0 + 6);
    chk("sb_left", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
